// File: rtl/dg_pkt_ctrl.sv
// Descriptor-driven packet generator: fetches descriptors from RAM and emits beats.
// Optional DG_LOOP_EN: list end / address wrap restarts at address 0 instead of stopping.
module dg_pkt_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [3:0]            o_da,
  output logic [2:0]            o_prior,
  output logic [9:0]            o_len,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_pkt_cnt
);

  localparam int unsigned LEN_W = 10;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned HI_W  = DATA_WIDTH - 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_GAP     = 3'd3,
    S_SEND    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [LEN_W-1:0]       beat_q, beat_d;
  logic [LEN_W-1:0]       gap_q, gap_d;
  logic [3:0]             da_q, da_d;
  logic [2:0]             prior_q, prior_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       wait_q, wait_d;

  logic                   ram_en_q, ram_en_d;
  logic                   valid_q, valid_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [LEN_W-1:0]       desc_len;
  logic [LEN_W-1:0]       desc_wait;
  logic                   unused_ram_bits;

  assign desc_len        = i_ram_data[16:7];
  assign desc_wait       = i_ram_data[26:17];
  assign unused_ram_bits = ^i_ram_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pkt_cnt_d = pkt_cnt_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    da_d      = da_q;
    prior_d   = prior_q;
    len_d     = len_q;
    wait_d    = wait_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d   = S_RD_REQ;
          addr_d    = '0;
          pkt_cnt_d = '0;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        da_d    = i_ram_data[3:0];
        prior_d = i_ram_data[6:4];
        len_d   = desc_len;
        wait_d  = desc_wait;
        beat_d  = '0;
        gap_d   = '0;
        if (desc_len == '0) begin
`ifdef DG_LOOP_EN
          state_d = S_RD_REQ;
          addr_d  = '0;
`else
          state_d = S_DONE;
`endif
        end else if (desc_wait == '0) begin
          state_d = S_SEND;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == wait_q - LEN_W'(1)) state_d = S_SEND;
        else                             gap_d   = gap_q + LEN_W'(1);
      end
      S_SEND: begin
        // o_valid is always high here, so i_ready alone completes a beat
        if (i_ready) begin
          if (beat_q == len_q - LEN_W'(1)) begin
            pkt_cnt_d = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
            state_d   = S_RD_REQ;
            addr_d    = addr_q + ADDR_WIDTH'(1);
`ifndef DG_LOOP_EN
            if (&addr_q) begin
              state_d = S_DONE;
              addr_d  = addr_q;
            end
`endif
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    ram_en_d = (state_d == S_RD_REQ);
    busy_d   = (state_d inside {S_RD_REQ, S_RD_WAIT, S_GAP, S_SEND});
    done_d   = (state_d == S_DONE);
    valid_d  = (state_d == S_SEND);
    sop_d    = valid_d && (beat_d == '0);
    eop_d    = valid_d && (beat_d == len_d - LEN_W'(1));
    data_d   = '0;
    if (valid_d) data_d = {HI_W'(addr_d), 16'(beat_d)};
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      pkt_cnt_q <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      da_q      <= '0;
      prior_q   <= '0;
      len_q     <= '0;
      wait_q    <= '0;
      ram_en_q  <= 1'b0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      pkt_cnt_q <= pkt_cnt_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      da_q      <= da_d;
      prior_q   <= prior_d;
      len_q     <= len_d;
      wait_q    <= wait_d;
      ram_en_q  <= ram_en_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_ram_en   = ram_en_q;
  assign o_ram_we   = 1'b0;
  assign o_ram_addr = addr_q;
  assign o_valid    = valid_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_da       = da_q;
  assign o_prior    = prior_q;
  assign o_len      = len_q;
  assign o_data     = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pkt_cnt  = pkt_cnt_q;

endmodule

// File: doc/dg_pkt_ctrl.md
DG_PKT_CTRL -- requirements
Module: dg_pkt_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: descriptor RAM word width and output data width; minimum 27.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: descriptor RAM address width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_start, input, 1: start pulse; sampled in IDLE or DONE only.
REQ-006 SHALL have port o_ram_en, output, 1: descriptor RAM enable; o_ram_we output, 1, tied 0.
REQ-007 SHALL have port o_ram_addr, output, ADDR_WIDTH: descriptor address.
REQ-008 SHALL have port i_ram_data, input, DATA_WIDTH: RAM read data, valid the cycle after o_ram_en.
REQ-009 SHALL have ports o_valid output 1, i_ready input 1: packet beat handshake.
REQ-010 SHALL have ports o_sop, o_eop, output, 1 each: first and last beat markers, qualified by o_valid.
REQ-011 SHALL have ports o_da output 4, o_prior output 3, o_len output 10: current descriptor fields, held stable for the whole packet.
REQ-012 SHALL have port o_data, output, DATA_WIDTH: beat payload.
REQ-013 SHALL have ports o_busy output 1, o_done output 1, o_pkt_cnt output 16.

Function
REQ-014 Descriptor format: [3:0] da, [6:4] prior, [16:7] len, [26:17] wait_clk_num; upper bits ignored.
REQ-015 States: IDLE, RD_REQ, RD_WAIT, GAP, SEND, DONE.
REQ-016 IDLE/DONE with i_start=1 -> RD_REQ; address and o_pkt_cnt cleared to 0.
REQ-017 RD_REQ: o_ram_en=1 for exactly one cycle -> RD_WAIT.
REQ-018 RD_WAIT: latch descriptor; len=0 -> DONE (end of list); wait_clk_num=0 -> SEND; else -> GAP.
REQ-019 GAP: o_valid=0 for exactly wait_clk_num cycles, then -> SEND.
REQ-020 SEND: o_valid=1; beat advances only on o_valid&&i_ready; beat index 0..len-1.
REQ-021 o_sop=1 on beat index 0; o_eop=1 on beat index len-1; both on the same beat when len=1.
REQ-022 o_data = {zero-extended descriptor address, beat index[15:0]}; o_data stable while o_valid&&!i_ready.
REQ-023 On eop transfer: o_pkt_cnt increments, saturating at 16'hFFFF; address+1 -> RD_REQ; if address was all ones -> DONE.
REQ-024 o_busy=1 in RD_REQ, RD_WAIT, GAP, SEND; o_done=1 only in DONE.
REQ-025 i_start outside IDLE/DONE SHALL be ignored.

Reset
REQ-026 rst=1 at a clock edge -> IDLE in any state, including mid-packet; no further beats.
REQ-027 Reset values: all outputs 0, address 0, o_pkt_cnt 0, beat and gap counters 0.

Configuration
REQ-028 Macro DG_LOOP_EN: when defined, the end-of-list descriptor (len=0) and address wrap SHALL restart at address 0 via RD_REQ without entering DONE; o_pkt_cnt keeps counting.
REQ-029 Without DG_LOOP_EN: stop in DONE per REQ-018/REQ-023.

Verification
REQ-030 Descriptors {da1,pr6,len64,wait0}, then len0, i_ready=1, i_start pulse -> 64 beats on consecutive cycles, sop beat0, eop beat63, o_da=1, o_prior=6, then o_done=1, o_pkt_cnt=1.
REQ-031 Descriptor wait=5, len=2 -> exactly 5 idle cycles between RD_WAIT and first o_valid.
REQ-032 i_ready toggled 1/0 during len=3 packet -> 3 transfers, o_data held during stalls, data low bits 0,1,2.
REQ-033 len=1 descriptor -> single beat with o_sop=o_eop=1.
REQ-034 rst asserted at beat 10 of len=1023 packet -> next cycle IDLE, all outputs 0; new i_start restarts at address 0.
REQ-035 DG_LOOP_EN defined, 2 valid descriptors then len0 -> packets repeat at addresses 0,1,0,1; o_done stays 0.
